// File: rtl/lcd_bus_arbiter_if.sv
// Shared bus between the frame producers, the arbiter and the lcd_write serializer.
// The slave side belongs to the arbiter; the master side is the producers plus the serializer.
interface lcd_bus_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int DW      = 9
);
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ-1:0]    wr_en;
  logic [NUM_REQ*DW-1:0] wr_data;
  logic [NUM_REQ-1:0]    grant;
  logic [NUM_REQ-1:0]    done;
  logic [DW-1:0]         data;
  logic                  en_write;
  logic                  wr_done;

  modport master (
    output req, wr_en, wr_data, wr_done,
    input  grant, done, data, en_write
  );

  modport slave (
    input  req, wr_en, wr_data, wr_done,
    output grant, done, data, en_write
  );
endinterface

// File: rtl/lcd_bus_arbiter.sv
// Burst-level arbiter in front of the single lcd_write serializer: requester 0 has strict
// priority (and is the only one served before init_done), the others share round-robin.
module lcd_bus_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int DW      = 9,
  parameter int TIMEOUT = 1024
) (
  input  logic             sys_clk_50MHz,
  input  logic             sys_rst_n,
  input  logic             init_done,
  lcd_bus_arbiter_if.slave bus,
  output logic             busy,
  output logic             timeout_err
);
  localparam int IW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, GRANTED, BUSY} state_t;

  state_t             state, state_nxt;
  logic [IW-1:0]      ptr, ptr_nxt, owner, winner;
  logic               win_vld;
  logic [CW-1:0]      wd_cnt;
  logic               wd_expired;
  logic [NUM_REQ-1:0] grant_nxt, done_nxt;
  logic               en_write_nxt, load_data, ptr_load, to_set;

  // k-th candidate of the cyclic search over 1..NUM_REQ-1 starting at p.
  function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] p, input int k);
    int v;
    v = ((int'(p) - 1 + k) % (NUM_REQ - 1)) + 1;
    return IW'(v);
  endfunction

  always_comb begin
    owner = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (bus.grant[i]) owner = IW'(i);
  end

  // Descending scan so the candidate closest to the pointer wins.
  always_comb begin
    winner  = '0;
    win_vld = 1'b0;
    if (bus.req[0]) begin
      win_vld = 1'b1;
    end else if (init_done) begin
      for (int k = NUM_REQ - 2; k >= 0; k--) begin
        if (bus.req[rr_idx(ptr, k)]) begin
          win_vld = 1'b1;
          winner  = rr_idx(ptr, k);
        end
      end
    end
    ptr_nxt = (winner == IW'(NUM_REQ - 1)) ? IW'(1) : winner + 1'b1;
  end

  assign wd_expired = (state == BUSY) && (wd_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge sys_clk_50MHz or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_vld) state_nxt = GRANTED;
      GRANTED: begin
        if (bus.wr_en[owner])     state_nxt = BUSY;
        else if (!bus.req[owner]) state_nxt = IDLE;
      end
      BUSY:    if (bus.wr_done || wd_expired) state_nxt = GRANTED;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    grant_nxt    = bus.grant;
    done_nxt     = '0;
    en_write_nxt = 1'b0;
    load_data    = 1'b0;
    ptr_load     = 1'b0;
    to_set       = 1'b0;
    case (state)
      IDLE: begin
        if (win_vld) begin
          grant_nxt         = '0;
          grant_nxt[winner] = 1'b1;
          ptr_load          = !bus.req[0];
        end
      end
      GRANTED: begin
        if (bus.wr_en[owner]) begin
          en_write_nxt = 1'b1;
          load_data    = 1'b1;
        end else if (!bus.req[owner]) begin
          grant_nxt = '0;
        end
      end
      BUSY: begin
        // A wr_done landing on the expiry cycle is an ordinary completion.
        if (bus.wr_done || wd_expired) begin
          done_nxt[owner] = 1'b1;
          to_set          = !bus.wr_done;
        end
      end
      default: grant_nxt = '0;
    endcase
  end

  always_ff @(posedge sys_clk_50MHz or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      bus.grant    <= '0;
      bus.done     <= '0;
      bus.en_write <= 1'b0;
      bus.data     <= '0;
      ptr          <= IW'(1);
      wd_cnt       <= '0;
      timeout_err  <= 1'b0;
    end else begin
      bus.grant    <= grant_nxt;
      bus.done     <= done_nxt;
      bus.en_write <= en_write_nxt;
      if (ptr_load)  ptr      <= ptr_nxt;
      if (load_data) bus.data <= bus.wr_data[owner*DW +: DW];
      if (load_data)
        wd_cnt <= '0;
      else if (state == BUSY && !wd_expired)
        wd_cnt <= wd_cnt + 1'b1;
      if (to_set) timeout_err <= 1'b1;
    end
  end

  assign busy = |bus.grant;
endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Bench for lcd_bus_arbiter: scripted scenarios plus a long randomized run, every cycle
// compared against a burst-level reference model of owner, outstanding word and watchdog.
module tb_lcd_bus_arbiter;
  localparam int N  = 3;
  localparam int DW = 9;
  localparam int TO = 16;
  localparam int VW = 2 * N + DW + 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic init_done = 1'b0;
  logic busy, timeout_err;

  lcd_bus_arbiter_if #(.NUM_REQ(N), .DW(DW)) bus ();

  lcd_bus_arbiter #(.NUM_REQ(N), .DW(DW), .TIMEOUT(TO)) dut (
    .sys_clk_50MHz(clk),
    .sys_rst_n    (rst_n),
    .init_done    (init_done),
    .bus          (bus),
    .busy         (busy),
    .timeout_err  (timeout_err)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the bus, whether a word is outstanding, how long it has waited.
  int             m_owner, m_wait, m_ptr;
  bit             m_pend, m_err, m_en;
  logic [N-1:0]   m_done;
  logic [DW-1:0]  m_data;

  // Producer / serializer stimulus state.
  bit want [N];
  int words_left [N];
  int bursts_left [N];
  int wpb, sdelay, max_delay, fixed_delay;
  bit hang, noise, rnd, early_drop;

  task automatic model_reset();
    m_owner = -1; m_wait = 0; m_ptr = 1;
    m_pend = 0; m_err = 0; m_en = 0; m_done = '0; m_data = '0;
  endtask

  task automatic model_step();
    int c;
    m_done = '0;
    m_en   = 1'b0;
    if (m_owner < 0) begin
      if (bus.req[0]) m_owner = 0;
      else if (init_done) begin
        for (int j = 0; j < N - 1; j++) begin
          c = m_ptr + j;
          if (c > N - 1) c -= N - 1;
          if (m_owner < 0 && bus.req[c]) begin
            m_owner = c;
            m_ptr   = (c == N - 1) ? 1 : c + 1;
          end
        end
      end
    end else if (!m_pend) begin
      if (bus.wr_en[m_owner]) begin
        m_data = bus.wr_data[m_owner*DW +: DW];
        m_en = 1'b1; m_pend = 1'b1; m_wait = 0;
      end else if (!bus.req[m_owner]) begin
        m_owner = -1;
      end
    end else begin
      if (bus.wr_done) begin
        m_done[m_owner] = 1'b1; m_pend = 1'b0;
      end else if (m_wait == TO - 1) begin
        m_err = 1'b1; m_done[m_owner] = 1'b1; m_pend = 1'b0;
      end else begin
        m_wait++;
      end
    end
  endtask

  function automatic logic [VW-1:0] exp_vec();
    logic [N-1:0] g;
    g = '0;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return {g, m_done, m_en, m_data, (m_owner >= 0), m_err};
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    return {bus.grant, bus.done, bus.en_write, bus.data, busy, timeout_err};
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic clear_prod();
    for (int i = 0; i < N; i++) begin
      want[i] = 1'b0; words_left[i] = 0; bursts_left[i] = 0;
    end
    wpb = 0; sdelay = -1; max_delay = 3; fixed_delay = -1;
    hang = 0; noise = 0; rnd = 0; early_drop = 0;
  endtask

  task automatic drive_cycle();
    bus.wr_en   = '0;
    bus.wr_done = 1'b0;
    bus.wr_data = (N*DW)'($urandom());
    for (int i = 0; i < N; i++) bus.req[i] = want[i];
    if (m_owner >= 0 && !m_pend && want[m_owner] && words_left[m_owner] > 0 &&
        (!rnd || $urandom_range(0, 3) != 0)) begin
      bus.wr_en[m_owner] = 1'b1;
      words_left[m_owner]--;
    end
    if (sdelay == 0) bus.wr_done = 1'b1;
    if (sdelay >= 0) sdelay--;
    if (noise) begin
      for (int i = 0; i < N; i++)
        if (i != m_owner && $urandom_range(0, 7) == 0) bus.wr_en[i] = 1'b1;
      if (m_pend && $urandom_range(0, 7) == 0) bus.wr_en[m_owner] = 1'b1;
      if (!m_pend && sdelay < 0 && $urandom_range(0, 7) == 0) bus.wr_done = 1'b1;
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic react();
    if (m_en) sdelay = hang ? -1 : (fixed_delay >= 0 ? fixed_delay : $urandom_range(0, max_delay));
    for (int i = 0; i < N; i++)
      if (m_done[i] && words_left[i] == 0) want[i] = 1'b0;
    if (early_drop && m_pend && words_left[m_owner] == 0) want[m_owner] = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!want[i] && m_owner != i && bursts_left[i] > 0 && (!rnd || $urandom_range(0, 3) == 0)) begin
        want[i] = 1'b1;
        words_left[i] = (wpb > 0) ? wpb : $urandom_range(1, 3);
        bursts_left[i]--;
      end
    end
  endtask

  task automatic test_reset();
    bus.req = '0; bus.wr_en = '0; bus.wr_data = '0; bus.wr_done = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL reset_async: got %h required %h", dut_vec(), exp_vec());
    end
    bus.req = '1; bus.wr_en = '1; bus.wr_done = 1'b1; init_done = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (dut_vec() !== '0) begin
      errors++; $display("FAIL reset_held: got %h required 0", dut_vec());
    end
    bus.req = '0; bus.wr_en = '0; bus.wr_done = 1'b0; init_done = 1'b0;
    #4 rst_n = 1'b1;
  endtask

  task automatic test_init_priority();
    int n_en, n_done;
    bit saw1;
    clear_prod(); init_done = 1'b0;
    want[0] = 1'b1; words_left[0] = 1;
    want[1] = 1'b1; words_left[1] = 1;
    n_en = 0; n_done = 0; saw1 = 0;
    for (int c = 0; c < 16; c++) begin
      drive_cycle();
      bus.wr_data[DW-1:0] = 9'h011;
      step(); react();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL init_prio cycle %0d: got %h required %h", c, dut_vec(), exp_vec());
      end
      if (bus.en_write && bus.data == 9'h011) n_en++;
      if (bus.done[0]) n_done++;
      if (bus.grant[1]) saw1 = 1'b1;
    end
    checks++;
    if (n_en != 1 || n_done != 1 || saw1) begin
      errors++; $display("FAIL init_prio_summary: en=%0d done0=%0d grant1=%0d required 1 1 0", n_en, n_done, saw1);
    end
  endtask

  task automatic test_round_robin();
    int seq_code, gap_code, n_grants, idle_run;
    logic [N-1:0] prev;
    clear_prod(); init_done = 1'b1; wpb = 2;
    want[1] = 1'b1; words_left[1] = 2; bursts_left[1] = 1;
    want[2] = 1'b1; words_left[2] = 2; bursts_left[2] = 1;
    seq_code = 0; gap_code = 0; n_grants = 0; idle_run = 0; prev = '0;
    for (int c = 0; c < 150; c++) begin
      drive_cycle(); step(); react();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL round_robin cycle %0d: got %h required %h", c, dut_vec(), exp_vec());
      end
      if (bus.grant != '0 && prev == '0) begin
        seq_code = seq_code * 10 + onehot_idx(bus.grant);
        if (n_grants > 0) gap_code = gap_code * 10 + idle_run;
        n_grants++;
      end
      idle_run = (bus.grant == '0) ? idle_run + 1 : 0;
      prev = bus.grant;
    end
    checks++;
    if (seq_code != 1212 || gap_code != 111) begin
      errors++; $display("FAIL rr_order: order %0d gaps %0d required 1212 111", seq_code, gap_code);
    end
  endtask

  task automatic test_no_preempt();
    int n_en1, bad_data, seq_code;
    bit inj;
    logic [N-1:0] prev;
    clear_prod(); init_done = 1'b1; fixed_delay = 6;
    want[1] = 1'b1; words_left[1] = 1;
    n_en1 = 0; bad_data = 0; seq_code = 0; inj = 0; prev = '0;
    for (int c = 0; c < 50; c++) begin
      drive_cycle();
      bus.wr_data[DW +: DW] = 9'h0A5;
      if (!inj && m_pend && m_owner == 1) begin
        want[0] = 1'b1; words_left[0] = 1; bus.req[0] = 1'b1;
        bus.wr_en[2] = 1'b1; bus.wr_data[2*DW +: DW] = 9'h1FF;
        inj = 1'b1;
      end
      step(); react();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL no_preempt cycle %0d: got %h required %h", c, dut_vec(), exp_vec());
      end
      if (bus.grant == 3'b010 && bus.en_write) n_en1++;
      if (inj && bus.grant == 3'b010 && bus.data !== 9'h0A5) bad_data++;
      if (bus.grant != '0 && prev == '0) seq_code = seq_code * 10 + onehot_idx(bus.grant);
      prev = bus.grant;
    end
    checks++;
    if (!inj || n_en1 != 1 || bad_data != 0 || seq_code != 10) begin
      errors++;
      $display("FAIL no_preempt_summary: inj=%0d en=%0d bad_data=%0d order=%0d required 1 1 0 10",
               inj, n_en1, bad_data, seq_code);
    end
  endtask

  task automatic test_timeout();
    int en_c[$];
    int done_c[$];
    int lat;
    clear_prod(); init_done = 1'b1; hang = 1;
    want[1] = 1'b1; words_left[1] = 2;
    for (int c = 0; c < 80; c++) begin
      drive_cycle(); step(); react();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL timeout cycle %0d: got %h required %h", c, dut_vec(), exp_vec());
      end
      if (bus.en_write) en_c.push_back(c);
      if (bus.done[1]) begin done_c.push_back(c); hang = 0; end
    end
    lat = (en_c.size() > 0 && done_c.size() > 0) ? done_c[0] - en_c[0] : -1;
    checks++;
    if (lat != TO || timeout_err !== 1'b1 || en_c.size() != 2 || done_c.size() != 2) begin
      errors++;
      $display("FAIL timeout_summary: latency=%0d err=%b en=%0d done=%0d required %0d 1 2 2",
               lat, timeout_err, en_c.size(), done_c.size(), TO);
    end
  endtask

  task automatic test_async_reset();
    bit reached;
    int first;
    logic [N-1:0] prev;
    clear_prod(); init_done = 1'b1; hang = 1;
    want[1] = 1'b1; words_left[1] = 1;
    reached = 0;
    for (int c = 0; c < 20 && !reached; c++) begin
      drive_cycle(); step(); react();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL async_rst_setup cycle %0d: got %h required %h", c, dut_vec(), exp_vec());
      end
      if (m_pend && m_owner == 1 && bus.grant == 3'b010) reached = 1;
    end
    #4 rst_n = 1'b0;
    #1;
    checks++;
    if (!reached || {bus.grant, bus.en_write, bus.done, busy, timeout_err} !== '0) begin
      errors++;
      $display("FAIL async_rst_drop: reached=%0d grant=%b en=%b done=%b err=%b required 1 000 0 000 0",
               reached, bus.grant, bus.en_write, bus.done, timeout_err);
    end
    model_reset(); clear_prod();
    bus.req = '0; bus.wr_en = '0; bus.wr_done = 1'b0;
    @(posedge clk);
    #5 rst_n = 1'b1;
    want[1] = 1'b1; words_left[1] = 1;
    want[2] = 1'b1; words_left[2] = 1;
    first = -1; prev = '0;
    for (int c = 0; c < 30; c++) begin
      drive_cycle(); step(); react();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL async_rst_after cycle %0d: got %h required %h", c, dut_vec(), exp_vec());
      end
      if (first < 0 && bus.grant != '0 && prev == '0) first = onehot_idx(bus.grant);
      prev = bus.grant;
    end
    checks++;
    if (first != 1) begin
      errors++; $display("FAIL async_rst_ptr: first grant %0d required 1", first);
    end
  endtask

  task automatic test_collision_idle_done();
    int n_done;
    clear_prod(); init_done = 1'b1; fixed_delay = TO - 1;
    want[2] = 1'b1; words_left[2] = 1;
    n_done = 0;
    for (int c = 0; c < 40; c++) begin
      drive_cycle();
      if (m_owner < 0) bus.wr_done = 1'b1;
      step(); react();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL collision cycle %0d: got %h required %h", c, dut_vec(), exp_vec());
      end
      n_done += $countones(bus.done);
    end
    checks++;
    if (n_done != 1 || timeout_err !== 1'b0) begin
      errors++; $display("FAIL collision_summary: done pulses %0d err %b required 1 0", n_done, timeout_err);
    end
  endtask

  task automatic test_random();
    clear_prod(); rnd = 1; noise = 1; max_delay = 18;
    for (int i = 0; i < N; i++) bursts_left[i] = 1000;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 63) == 0) init_done = ~init_done;
      early_drop = ($urandom_range(0, 1) == 1);
      drive_cycle(); step(); react();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL random cycle %0d: got %h required %h", c, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    clear_prod();
    test_reset();
    test_init_priority();
    test_round_robin();
    test_no_preempt();
    test_timeout();
    test_async_reset();
    test_collision_idle_done();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
